// File: rtl/fir_tap_sequencer.sv
// FIR tap sequencer: walks the sample/coefficient address space for one output per
// accepted input sample, drives MAC strobes, and zeroes the sample history on flush.
// Optional symmetric-coefficient mode (macro FIR_SEQ_SYMM_EN) folds the loop in half,
// reading two samples per step that share one coefficient.
module fir_tap_sequencer #(
  parameter int NTAPS   = 175,
  parameter int MAC_LAT = 2,
  parameter int AW      = $clog2(NTAPS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          flush,
  output logic          wr_en,
  output logic          wr_zero,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] smp_addr,
  output logic [AW-1:0] smp_addr_b,
  output logic          pair_en,
  output logic [AW-1:0] coef_addr,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          busy
);

  localparam logic [AW-1:0] LastIdx = AW'(NTAPS - 1);
`ifdef FIR_SEQ_SYMM_EN
  localparam logic [AW-1:0] KLast = AW'((NTAPS - 1) / 2);
`else
  localparam logic [AW-1:0] KLast = AW'(NTAPS - 1);
`endif
  localparam int DW = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;
  localparam logic [DW-1:0] DLast = DW'((MAC_LAT > 0) ? MAC_LAT - 1 : 0);

  typedef enum logic [2:0] {StIdle, StClr, StRun, StDrain, StOut} state_e;

  state_e        state_q;
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] k_q;
  logic [AW-1:0] c_q;
  logic [DW-1:0] d_q;

  // (a - b) mod NTAPS; one extra bit keeps a + NTAPS from overflowing when NTAPS = 2^AW.
  function automatic logic [AW-1:0] sub_mod(input logic [AW-1:0] a, input logic [AW-1:0] b);
    logic [AW:0] s;
    if (a >= b) s = {1'b0, a} - {1'b0, b};
    else        s = {1'b0, a} + (AW + 1)'(NTAPS) - {1'b0, b};
    return s[AW-1:0];
  endfunction

  // Sequencer state, write pointer and loop counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      wptr_q  <= '0;
      k_q     <= '0;
      c_q     <= '0;
      d_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          // flush wins over a simultaneous sample
          if (flush) begin
            state_q <= StClr;
            c_q     <= '0;
          end else if (in_valid) begin
            state_q <= StRun;
            k_q     <= '0;
          end
        end
        StClr: begin
          if (c_q == LastIdx) begin
            wptr_q  <= '0;
            state_q <= StIdle;
          end else begin
            c_q <= c_q + 1'b1;
          end
        end
        StRun: begin
          if (k_q == KLast) begin
            k_q <= '0;
            d_q <= '0;
            state_q <= (MAC_LAT == 0) ? StOut : StDrain;
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        StDrain: begin
          if (d_q == DLast) state_q <= StOut;
          else              d_q     <= d_q + 1'b1;
        end
        StOut: begin
          if (out_ready) begin
            wptr_q  <= (wptr_q == LastIdx) ? '0 : wptr_q + 1'b1;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  // Output decode from state; everything is held low while reset is asserted.
  always_comb begin
    in_ready   = 1'b0;
    busy       = 1'b0;
    out_valid  = 1'b0;
    wr_en      = 1'b0;
    wr_zero    = 1'b0;
    wr_addr    = '0;
    smp_addr   = '0;
    smp_addr_b = '0;
    pair_en    = 1'b0;
    coef_addr  = '0;
    mac_en     = 1'b0;
    mac_clr    = 1'b0;
    if (!reset) begin
      busy = (state_q != StIdle);
      unique case (state_q)
        StIdle: begin
          in_ready = ~flush;
          wr_en    = in_valid & ~flush;
          wr_addr  = wptr_q;
        end
        StClr: begin
          wr_en   = 1'b1;
          wr_zero = 1'b1;
          wr_addr = c_q;
        end
        StRun: begin
          mac_en    = 1'b1;
          mac_clr   = (k_q == '0);
          coef_addr = k_q;
          smp_addr  = sub_mod(wptr_q, k_q);
`ifdef FIR_SEQ_SYMM_EN
          smp_addr_b = sub_mod(wptr_q, LastIdx - k_q);
          pair_en    = (k_q != (LastIdx - k_q));
`endif
        end
        StOut:   out_valid = 1'b1;
        default: ;
      endcase
    end
  end

endmodule
